// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
package loader_pkg;

    // Loader frame-parsing states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHK,
        ST_FIN,
        ST_FAIL
    } ld_state_e;

    // UART receiver bit-phase states.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0]  HDR_BYTE         = 8'hA5;
    localparam int unsigned CLKS_PER_BIT_DEF = 434;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling timer and
// LSB-first shift register. Emits a one-cycle rx_valid per byte with the
// stop-bit framing error alongside.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int unsigned   CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    logic            meta_q, sync_q, prev_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic [7:0]      byte_q, byte_d;
    logic            ferr_q, ferr_d;

    // Synchronizer resets low so that a start is only recognised after the
    // line has been seen high; this makes the receiver skip any byte that was
    // already in flight when reset was released.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= RX;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Receiver state, timer and data registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            byte_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            byte_q  <= byte_d;
            ferr_q  <= ferr_d;
        end
    end

    // Bit timing: half a bit to the start centre, then a full bit per sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        byte_d  = byte_q;
        ferr_d  = ferr_q;
        unique case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    byte_d  = shift_q;
                    ferr_d  = !sync_q;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_valid = valid_q;
    assign rx_byte  = byte_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: parses A5 / LEN_LO / LEN_HI / data / checksum
// frames from the UART and writes each assembled word into instruction
// memory while holding the CPU in reset.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned ADDR_W       = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RX,
    input  logic        LOAD_EN,
    output logic        CPU_HOLD,
    output logic        IM_WE,
    output logic [31:0] IM_ADDR,
    output logic [31:0] IM_WDATA,
    output logic        DONE,
    output logic        ERR
);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .CLK      (CLK),
        .RESET    (RESET),
        .RX       (RX),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ferr  (rx_ferr)
    );

    ld_state_e   state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [16:0] widx_q, widx_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [7:0]  chk_q, chk_d;
    logic [31:0] word_q, word_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    // Loader state and write-port registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            chk_q   <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            chk_q   <= chk_d;
            word_q  <= word_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Frame parser: advances one step per received byte; disarming wins.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        chk_d   = chk_q;
        word_d  = word_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (!LOAD_EN) begin
            state_d = ST_IDLE;
        end else if (rx_valid) begin
            unique case (state_q)
                ST_IDLE, ST_FIN, ST_FAIL: begin
                    if (!rx_ferr && rx_byte == HDR_BYTE) begin
                        state_d = ST_LEN_LO;
                        widx_d  = '0;
                        bidx_d  = '0;
                        chk_d   = '0;
                    end
                end
                ST_LEN_LO: begin
                    if (rx_ferr) begin
                        state_d = ST_FAIL;
                    end else begin
                        len_d[7:0] = rx_byte;
                        state_d    = ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (rx_ferr) begin
                        state_d = ST_FAIL;
                    end else begin
                        len_d[15:8] = rx_byte;
                        if ({rx_byte, len_q[7:0]} == 16'd0) begin
                            state_d = ST_CHK;
                        end else if (32'({rx_byte, len_q[7:0]}) > (32'd1 << ADDR_W)) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_ferr) begin
                        state_d = ST_FAIL;
                    end else begin
                        word_d[8*bidx_q +: 8] = rx_byte;
                        chk_d  = chk_q ^ rx_byte;
                        bidx_d = bidx_q + 2'd1;
                        if (bidx_q == 2'd3) begin
                            we_d    = 1'b1;
                            addr_d  = 32'({widx_q[ADDR_W-1:0], 2'b00});
                            wdata_d = word_d;
                            widx_d  = widx_q + 17'd1;
                            if ((widx_q + 17'd1) == {1'b0, len_q}) begin
                                state_d = ST_CHK;
                            end
                        end
                    end
                end
                ST_CHK: begin
                    state_d = (!rx_ferr && rx_byte == chk_q) ? ST_FIN : ST_FAIL;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign CPU_HOLD = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHK);
    assign DONE     = (state_q == ST_FIN);
    assign ERR      = (state_q == ST_FAIL);
    assign IM_WE    = we_q;
    assign IM_ADDR  = addr_q;
    assign IM_WDATA = wdata_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader with a frame-level reference model.
module tb_uart_prog_loader;

    localparam int C  = 4;
    localparam int AW = 4;
    localparam int G  = 2 * C;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        load_en;
    logic        CPU_HOLD, IM_WE, DONE, ERR;
    logic [31:0] IM_ADDR, IM_WDATA;

    uart_prog_loader #(
        .CLKS_PER_BIT(C),
        .ADDR_W      (AW)
    ) dut (
        .CLK      (clk),
        .RESET    (rst),
        .RX       (rx),
        .LOAD_EN  (load_en),
        .CPU_HOLD (CPU_HOLD),
        .IM_WE    (IM_WE),
        .IM_ADDR  (IM_ADDR),
        .IM_WDATA (IM_WDATA),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame-level model state
    bit          m_active, m_done, m_err;
    int          m_n;
    logic [7:0]  fb[$];
    logic [31:0] exp_addr[$], exp_data[$];
    logic [31:0] held_addr, held_data;
    logic [31:0] wr_addr_log[$], wr_data_log[$];
    int          nwr = 0;
    bit          prev_we = 1'b0;
    logic [7:0]  txq[$];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_done = 0; m_err = 0;
        exp_addr.delete(); exp_data.delete();
        held_addr = '0; held_data = '0;
    endtask

    // Applies the frame rules to one received byte.
    task automatic model_byte(input logic [7:0] b, input bit ferr);
        int L;
        logic [7:0] x;
        if (!load_en) return;
        if (!m_active) begin
            if (!ferr && b == 8'hA5) begin
                m_active = 1; m_done = 0; m_err = 0;
                fb.delete();
            end
            return;
        end
        if (ferr) begin
            m_active = 0; m_err = 1;
            return;
        end
        fb.push_back(b);
        L = fb.size();
        if (L == 1) return;
        if (L == 2) begin
            m_n = int'(fb[0]) | (int'(fb[1]) << 8);
            if (m_n > (1 << AW)) begin
                m_active = 0; m_err = 1;
            end
            return;
        end
        if (L - 2 <= 4 * m_n) begin
            if ((L - 2) % 4 == 0) begin
                exp_addr.push_back(32'(((L - 2) / 4 - 1) * 4));
                exp_data.push_back({fb[L-1], fb[L-2], fb[L-3], fb[L-4]});
            end
            return;
        end
        x = '0;
        for (int i = 2; i < L - 1; i++) x ^= fb[i];
        if (fb[L-1] == x) m_done = 1; else m_err = 1;
        m_active = 0;
    endtask

    // Write-port checker: every strobe must match the next expected write,
    // last single cycle, and leave address/data held afterwards.
    always @(negedge clk) begin
        if (rst) begin
            prev_we = 1'b0;
        end else begin
            if (IM_WE) begin
                nwr++;
                wr_addr_log.push_back(IM_ADDR);
                wr_data_log.push_back(IM_WDATA);
                chk32("we_single_cycle", 32'(prev_we), 32'd0);
                if (exp_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", IM_ADDR, IM_WDATA);
                end else begin
                    held_addr = exp_addr.pop_front();
                    held_data = exp_data.pop_front();
                    chk32("wr_addr", IM_ADDR, held_addr);
                    chk32("wr_data", IM_WDATA, held_data);
                end
            end else begin
                chk32("held_addr", IM_ADDR, held_addr);
                chk32("held_data", IM_WDATA, held_data);
            end
            prev_we = IM_WE;
        end
    end

    // Drives one 8N1 byte; optional reset pulse during data bit rst_bit.
    task automatic send_byte(input logic [7:0] b, input bit stop, input int gap, input int rst_bit);
        logic v;
        for (int i = 0; i < 10; i++) begin
            v = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
            @(negedge clk);
            rx = v;
            if (i == rst_bit) begin
                rst = 1'b1;
                #1;
                chk32("rst_async_flags", {28'd0, CPU_HOLD, IM_WE, DONE, ERR}, 32'd0);
                chk32("rst_async_addr", IM_ADDR, 32'd0);
                chk32("rst_async_data", IM_WDATA, 32'd0);
                model_reset();
            end
            repeat (C - 1) @(negedge clk);
            if (i == rst_bit) rst = 1'b0;
        end
        if (rst_bit < 0) model_byte(b, !stop);
        if (gap > 0) begin
            @(negedge clk);
            rx = 1'b1;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic send_q(input int gap);
        while (txq.size() > 0) send_byte(txq.pop_front(), 1'b1, gap, -1);
    endtask

    task automatic settle_and_check(input string tag);
        @(negedge clk);
        rx = 1'b1;
        repeat (3 * C) @(negedge clk);
        chk32({tag, "_hold"}, 32'(CPU_HOLD), 32'(m_active));
        chk32({tag, "_done"}, 32'(DONE), 32'(m_done));
        chk32({tag, "_err"},  32'(ERR),  32'(m_err));
    endtask

    int n0, t;

    initial begin
        rst = 1'b1; rx = 1'b1; load_en = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk32("reset_flags", {28'd0, CPU_HOLD, IM_WE, DONE, ERR}, 32'd0);
        chk32("reset_addr", IM_ADDR, 32'd0);
        chk32("reset_data", IM_WDATA, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Good two-word frame; checksum = 13 ^ 93 ^ 10 = 90
        n0 = nwr;
        send_byte(8'hA5, 1'b1, 0, -1);
        t = 0;
        while (!CPU_HOLD && t < 4 * C) begin @(negedge clk); t++; end
        chk32("hold_rise_after_hdr", 32'(CPU_HOLD), 32'd1);
        txq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_q(G);
        settle_and_check("good");
        chk32("good_nwr", 32'(nwr - n0), 32'd2);
        chk32("good_done_lit", 32'(DONE), 32'd1);
        chk32("good_w0_addr", wr_addr_log[n0], 32'h0000_0000);
        chk32("good_w0_data", wr_data_log[n0], 32'h0000_0013);
        chk32("good_w1_addr", wr_addr_log[n0+1], 32'h0000_0004);
        chk32("good_w1_data", wr_data_log[n0+1], 32'h0010_0093);

        // Same frame, bad checksum
        n0 = nwr;
        txq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
        send_q(G);
        settle_and_check("badchk");
        chk32("badchk_nwr", 32'(nwr - n0), 32'd2);
        chk32("badchk_err_lit", {30'd0, DONE, ERR}, 32'd1);

        // Empty frame, then oversize length
        n0 = nwr;
        txq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_q(G);
        settle_and_check("empty");
        chk32("empty_done_lit", {30'd0, DONE, ERR}, 32'd2);
        txq = '{8'hA5, 8'h11, 8'h00};
        send_q(G);
        settle_and_check("oversize");
        chk32("oversize_err_lit", {30'd0, DONE, ERR}, 32'd1);
        chk32("empty_oversize_nwr", 32'(nwr - n0), 32'd0);

        // Framing error on the 2nd data byte, trailing bytes ignored
        n0 = nwr;
        txq = '{8'hA5, 8'h01, 8'h00, 8'h13};
        send_q(G);
        send_byte(8'h00, 1'b0, G, -1);
        txq = '{8'h00, 8'h00, 8'h90, 8'h55, 8'hFF};
        send_q(G);
        settle_and_check("ferr");
        chk32("ferr_err_lit", {30'd0, DONE, ERR}, 32'd1);
        chk32("ferr_nwr", 32'(nwr - n0), 32'd0);
        txq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_q(G);
        settle_and_check("after_garbage");
        chk32("after_garbage_nwr", 32'(nwr - n0), 32'd2);

        // Disarm after the first word
        n0 = nwr;
        txq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        send_q(G);
        settle_and_check("pre_disarm");
        chk32("pre_disarm_nwr", 32'(nwr - n0), 32'd1);
        @(negedge clk);
        load_en = 1'b0;
        @(posedge clk);
        #1;
        chk32("disarm_hold_next_cycle", 32'(CPU_HOLD), 32'd0);
        m_active = 0;
        txq = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h90, 8'hA5, 8'h02, 8'h00};
        send_q(G);
        settle_and_check("disarmed");
        chk32("disarmed_nwr", 32'(nwr - n0), 32'd1);
        load_en = 1'b1;
        repeat (G) @(negedge clk);

        // Reset in the middle of a word, then a back-to-back frame
        txq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
        send_q(G);
        send_byte(8'h00, 1'b1, 12 * C, 4);
        settle_and_check("after_reset");
        n0 = nwr;
        txq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_q(0);
        settle_and_check("b2b");
        chk32("b2b_done_lit", {30'd0, DONE, ERR}, 32'd2);
        chk32("b2b_nwr", 32'(nwr - n0), 32'd2);

        chk32("no_pending_writes", 32'(exp_addr.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
